// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: shared types and constants for the bit-serial ALU sequencer.
//   state_t   - sequencer states (IDLE, RUN, DONE)
//   AND..NOR  - 4-bit ctrl encodings {invertA, invertB, aluOp[1:0]}
//   slice_op  - aluOp actually presented to the 1-bit slice
package alu_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111;
  localparam logic [3:0] NOR = 4'b1100;

  // SLT runs the slice as a subtractor; the less/set path is resolved
  // by the sequencer at the MSB instead of inside the slice chain.
  function automatic logic [1:0] slice_op(input logic [3:0] ctrl);
    return (ctrl[1:0] == 2'b11) ? 2'b10 : ctrl[1:0];
  endfunction

endpackage

// File: rtl/ALU_1bit_special_adv.sv
// ALU_1bit_special_adv: combinational 1-bit ALU slice.
//   a, b              - operand bits
//   invertA, invertB  - invert the operand bit before use
//   carryIn           - carry from the less significant slice
//   less              - value passed through for aluOp 11
//   aluOp             - 00 AND, 01 OR, 10 ADD, 11 less
//   result            - selected output bit
//   carryOut          - adder carry out
//   set               - sign of the difference, overflow-corrected (MSB use)
//   overflow          - signed overflow of the adder (MSB use)
module ALU_1bit_special_adv (
  input  logic       a,
  input  logic       b,
  input  logic       invertA,
  input  logic       invertB,
  input  logic       carryIn,
  input  logic       less,
  input  logic [1:0] aluOp,
  output logic       result,
  output logic       carryOut,
  output logic       set,
  output logic       overflow
);

  logic aa;
  logic bb;
  logic sum;

  always_comb begin
    aa       = a ^ invertA;
    bb       = b ^ invertB;
    sum      = aa ^ bb ^ carryIn;
    carryOut = (aa & bb) | (carryIn & (aa ^ bb));
    overflow = carryIn ^ carryOut;
    // Correcting with overflow makes SLT right even when a-b overflows.
    set      = sum ^ overflow;
    unique case (aluOp)
      2'b00:   result = aa & bb;
      2'b01:   result = aa | bb;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer driving one ALU_1bit_special_adv
// slice LSB first, one bit per clock.
//   clk_i, rst_n         - clock (rising edge), async active-low reset
//   start_i              - request, sampled only in IDLE
//   a_i, b_i, ctrl_i     - operands and {invertA, invertB, aluOp}, latched on accept
//   busy_o               - high while RUN
//   done_o               - one-cycle pulse when result/flags are updated
//   result_o, zero_o     - assembled result and result==0, held until next done
//   overflow_o, cout_o   - slice overflow / carryOut at the MSB
module alu_serial_seq
  import alu_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             cout_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] sr;

  logic             s_result;
  logic             s_cout;
  logic             s_set;
  logic             s_ovf;
  logic [WIDTH-1:0] next_sr;
  logic [WIDTH-1:0] final_res;

  ALU_1bit_special_adv u_slice (
    .a        (a_q[cnt]),
    .b        (b_q[cnt]),
    .invertA  (ctrl_q[3]),
    .invertB  (ctrl_q[2]),
    .carryIn  (carry),
    .less     (1'b0),
    .aluOp    (slice_op(ctrl_q)),
    .result   (s_result),
    .carryOut (s_cout),
    .set      (s_set),
    .overflow (s_ovf)
  );

  // Shifting in from the MSB end puts bit i at position i after WIDTH shifts.
  always_comb begin
    next_sr   = {s_result, sr[WIDTH-1:1]};
    final_res = next_sr;
    if (ctrl_q[1:0] == 2'b11) final_res = {{(WIDTH-1){1'b0}}, s_set};
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      carry      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      sr         <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
      cout_o     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            ctrl_q <= ctrl_i;
            cnt    <= '0;
            carry  <= ctrl_i[2];
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          carry <= s_cout;
          sr    <= next_sr;
          if (cnt == LAST) begin
            result_o   <= final_res;
            zero_o     <= (final_res == '0);
            overflow_o <= s_ovf;
            cout_o     <= s_cout;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: scoreboard bench for alu_serial_seq. The stimulus
// process predicts acceptance and pushes expected results; a negedge
// monitor pops and compares when a done is due and checks held outputs.
module tb_alu_serial_seq;
  import alu_serial_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic         cout;
    int           done_at;
  } exp_t;

  logic         clk_i;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [3:0]   ctrl_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         overflow_o;
  logic         cout_o;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .ctrl_i     (ctrl_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o),
    .cout_o     (cout_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_free = 0;
  int   run_n = 0;
  logic run_valid = 1'b0;
  exp_t q[$];
  exp_t last;

  logic [3:0] ops [6] = '{AND, OR, ADD, SUB, SLT, NOR};

  always @(posedge clk_i) cyc++;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: the slice chain is an ordinary WIDTH-bit addition of the
  // (optionally inverted) operands with carry-in invertB.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] c);
    exp_t e;
    logic [W-1:0] aa, bb, r;
    logic [W:0]   s;
    aa = c[3] ? ~a : a;
    bb = c[2] ? ~b : b;
    s  = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c[2]};
    r  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (aa[W-1] == bb[W-1]) && (r[W-1] != aa[W-1]);
    case (c[1:0])
      2'b00:   e.res = aa & bb;
      2'b01:   e.res = aa | bb;
      2'b10:   e.res = r;
      default: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
    endcase
    e.zero    = (e.res == '0);
    e.done_at = 0;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.res = '0; e.zero = 1'b1; e.ovf = 1'b0; e.cout = 1'b0; e.done_at = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = '0;
      1:       v = 32'h8000_0000 | W'($urandom_range(0, 3));
      2:       v = 32'h7FFF_FFFF - W'($urandom_range(0, 3));
      3:       v = '1 - W'($urandom_range(0, 3));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One cycle of stimulus, issued at a negedge; predicts acceptance at the
  // following posedge (cyc+1).
  task automatic drive_cycle(input logic st, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [3:0] c);
    exp_t e;
    start_i = st;
    a_i     = a;
    b_i     = b;
    ctrl_i  = c;
    if (rst_n && st && (cyc + 1 >= next_free)) begin
      e         = model(a, b, c);
      e.done_at = cyc + 1 + W;
      q.push_back(e);
      run_n     = cyc + 1;
      run_valid = 1'b1;
      next_free = cyc + 1 + W + 2;
    end
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    while (cyc + 1 < next_free) drive_cycle(1'b0, $urandom, $urandom, 4'($urandom));
    drive_cycle(1'b1, a, b, c);
  endtask

  // Monitor: compares outputs every negedge against the held expectation,
  // taking the next queued one exactly when its done cycle arrives.
  always @(negedge clk_i) begin
    logic exp_done, exp_busy;
    exp_done = 1'b0;
    if (q.size() > 0 && cyc == q[0].done_at) begin
      last     = q.pop_front();
      exp_done = 1'b1;
    end
    exp_busy = run_valid && (cyc >= run_n) && (cyc < run_n + W);
    chk("done", W'(done_o), W'(exp_done));
    chk("busy", W'(busy_o), W'(exp_busy));
    chk("result", result_o, last.res);
    chk("zero", W'(zero_o), W'(last.zero));
    chk("overflow", W'(overflow_o), W'(last.ovf));
    chk("cout", W'(cout_o), W'(last.cout));
  end

  initial begin
    int guard;
    last    = reset_exp();
    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    ctrl_i  = '0;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    drive_cycle(1'b0, '0, '0, '0);

    // Directed cases
    issue(32'h7FFF_FFFF, 32'h0000_0001, ADD);
    issue(32'h0000_0005, 32'h0000_0005, SUB);
    issue(32'hFFFF_FFFD, 32'h0000_0002, SLT);
    issue(32'h8000_0000, 32'h0000_0001, SLT);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, SLT);
    issue(32'hF0F0_A5A5, 32'h0FF0_FF00, AND);
    issue(32'hF0F0_A5A5, 32'h0FF0_FF00, OR);
    issue(32'hF0F0_A5A5, 32'h0FF0_FF00, NOR);

    // Random sparse requests, including starts during RUN/DONE
    for (int i = 0; i < 400; i++)
      drive_cycle($urandom_range(0, 3) == 0, rnd_operand(), rnd_operand(),
                  ops[$urandom_range(0, 5)]);

    // start held high with operands changing every cycle
    while (cyc + 1 < next_free) drive_cycle(1'b0, '0, '0, '0);
    for (int i = 0; i < 5 * (W + 2); i++)
      drive_cycle(1'b1, rnd_operand(), rnd_operand(), ops[$urandom_range(0, 5)]);
    start_i = 1'b0;

    // Reset in cycle 10 of RUN
    issue(32'h1234_5678, 32'h1111_1111, ADD);
    repeat (9) drive_cycle(1'b0, $urandom, $urandom, 4'($urandom));
    #1;
    rst_n     = 1'b0;
    q.delete();
    last      = reset_exp();
    run_valid = 1'b0;
    next_free = 0;
    #1;
    chk("rst_busy", W'(busy_o), W'(0));
    chk("rst_done", W'(done_o), W'(0));
    chk("rst_result", result_o, '0);
    chk("rst_zero", W'(zero_o), W'(1));
    chk("rst_overflow", W'(overflow_o), W'(0));
    chk("rst_cout", W'(cout_o), W'(0));
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    issue(32'h0FFF_FFFF, 32'h7000_0001, ADD);

    // Drain outstanding results with a bounded wait
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      drive_cycle(1'b0, '0, '0, '0);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d required=0", q.size());
    end
    repeat (3) drive_cycle(1'b0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
